// File: rtl/mem_responder_pkg.sv
// Shared definitions for the RAM request path: op3 codes, access sizes,
// responder FSM states and the op3 decoder used by the responder.
package mem_responder_pkg;

    // SPARC op3 codes seen on the RAM request interface
    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;

    // Access size encodings
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Decoded view of an op3 code
    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic [1:0] size;
        logic       sgn;
    } op_dec_t;

    // Map op3 to access attributes; anything unsupported decodes as invalid
    function automatic op_dec_t decode_op(input logic [5:0] op);
        op_dec_t d;
        case (op)
            OP_LD:   d = '{1'b1, 1'b1, SZ_WORD, 1'b0};
            OP_LDUB: d = '{1'b1, 1'b1, SZ_BYTE, 1'b0};
            OP_LDUH: d = '{1'b1, 1'b1, SZ_HALF, 1'b0};
            OP_LDSB: d = '{1'b1, 1'b1, SZ_BYTE, 1'b1};
            OP_LDSH: d = '{1'b1, 1'b1, SZ_HALF, 1'b1};
            OP_ST:   d = '{1'b1, 1'b0, SZ_WORD, 1'b0};
            OP_STB:  d = '{1'b1, 1'b0, SZ_BYTE, 1'b0};
            OP_STH:  d = '{1'b1, 1'b0, SZ_HALF, 1'b0};
            default: d = '{1'b0, 1'b0, SZ_BYTE, 1'b0};
        endcase
        return d;
    endfunction

    // True when the byte offset is not a multiple of the access size
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// RAM request interface between the control unit (master) and the
// memory responder (slave).
interface mem_responder_if;
    logic        RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MFC;
    logic        Error;

    modport master (
        output RAM_enable, RAM_OpCode, Address, DataIn,
        input  DataOut, MFC, Error
    );

    modport slave (
        input  RAM_enable, RAM_OpCode, Address, DataIn,
        output DataOut, MFC, Error
    );
endinterface

// File: rtl/mem_responder_load_align.sv
// mem_load_align: picks the addressed byte/halfword out of a big-endian
// word and zero- or sign-extends it to 32 bits. Purely combinational.
module mem_load_align
    import mem_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the byte lane; offset 0 is the most significant byte
    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            2'd3:    w_byte = i_word[7:0];
            default: w_byte = 8'h00;
        endcase
    end

    // Select the halfword lane; only the upper offset bit matters
    always_comb begin
        w_half = i_off[1] ? i_word[15:0] : i_word[31:16];
    end

    // Extend the selected lane according to size and signedness
    always_comb begin
        o_data = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: o_data = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'h00_0000, w_byte};
            SZ_HALF: o_data = i_signed ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
            SZ_WORD: o_data = i_word;
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte-addressed big-endian RAM that services one request
// at a time from the control unit and reports completion on MFC with a
// four-phase handshake after a fixed LATENCY.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic             Clk,
    input  logic             RESET,
    mem_responder_if.slave   bus
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [5:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_din;
    logic              r_mfc, w_mfc_nxt;
    logic              r_err, w_err_nxt;
    logic [31:0]       r_dout, w_dout_nxt;
    logic              w_capture;
    logic              w_we;

    logic [7:0]        r_mem [DEPTH];

    op_dec_t           w_dec;
    logic              w_err;
    logic [1:0]        w_off;
    logic [ADDR_W-3:0] w_wa;
    logic [31:0]       w_raw;
    logic [31:0]       w_ldata;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_unused_addr;

    // Address bits above the decoded range alias and are deliberately dropped
    assign w_unused_addr = ^bus.Address[31:ADDR_W];

    assign w_dec = decode_op(r_op);
    assign w_off = r_addr[1:0];
    assign w_wa  = r_addr[ADDR_W-1:2];
    assign w_err = !w_dec.valid || misaligned(w_dec.size, w_off);

    // Whole containing word, most significant byte at the lowest address
    assign w_raw = {r_mem[{w_wa, 2'b00}], r_mem[{w_wa, 2'b01}],
                    r_mem[{w_wa, 2'b10}], r_mem[{w_wa, 2'b11}]};

    mem_load_align u_load_align (
        .i_word   (w_raw),
        .i_off    (w_off),
        .i_size   (w_dec.size),
        .i_signed (w_dec.sgn),
        .o_data   (w_ldata)
    );

    // Byte enables (bit i = offset i) and lane-replicated store data
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = r_din;
        case (w_dec.size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{r_din[7:0]}};
            end
            SZ_HALF: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_din[15:0]}};
            end
            SZ_WORD: begin
                w_be    = 4'b1111;
                w_wdata = r_din;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = r_din;
            end
        endcase
    end

    // Next-state, counter and response logic of the request FSM
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mfc_nxt   = r_mfc;
        w_err_nxt   = r_err;
        w_dout_nxt  = r_dout;
        w_capture   = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.RAM_enable) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_DONE;
                    w_mfc_nxt   = 1'b1;
                    w_err_nxt   = w_err;
                    if (w_err) begin
                        w_we = 1'b0;
                    end else if (w_dec.is_load) begin
                        w_dout_nxt = w_ldata;
                    end else begin
                        w_we = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                if (!bus.RAM_enable) begin
                    w_state_nxt = ST_IDLE;
                    w_mfc_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_mfc_nxt   = 1'b0;
                w_err_nxt   = 1'b0;
            end
        endcase
    end

    // FSM state, counter and registered response outputs
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_mfc   <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mfc   <= w_mfc_nxt;
            r_err   <= w_err_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // Latch the request so later input changes cannot affect it
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            r_op   <= 6'd0;
            r_addr <= '0;
            r_din  <= 32'h0000_0000;
        end else if (w_capture) begin
            r_op   <= bus.RAM_OpCode;
            r_addr <= bus.Address[ADDR_W-1:0];
            r_din  <= bus.DataIn;
        end
    end

    // Storage write port; contents survive reset by design
    always_ff @(posedge Clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[{w_wa, 2'(i)}] <= w_wdata[31-8*i -: 8];
                end
            end
        end
    end

    assign bus.DataOut = r_dout;
    assign bus.MFC     = r_mfc;
    assign bus.Error   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a driver issues requests and pushes
// the response predicted by a byte-array reference model into a queue; a
// monitor pops and compares each time MFC rises.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int AW    = 9;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic        err;
        logic [31:0] dout;
        int          cap;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if bus();

    mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .Clk   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    exp_t        q[$];
    exp_t        mon_e;
    logic [7:0]  mm [DEPTH];
    logic [31:0] m_dout;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        mfc_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising MFC must match the oldest outstanding prediction
    always @(negedge clk) begin
        if (bus.MFC === 1'b1 && mfc_prev !== 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mfc: got MFC=1 expected no completion (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("error_flag", 32'(bus.Error), 32'(mon_e.err));
                chk("dataout", bus.DataOut, mon_e.dout);
                chk("latency", 32'(cyc - mon_e.cap), 32'(LAT));
            end
        end
        mfc_prev <= bus.MFC;
    end

    // Reference model: applies the access to the byte array, returns error
    task automatic model(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] din, output logic err);
        int     a;
        int     sz;
        bit     ld;
        bit     sg;
        bit     ok;
        longint v;
        a  = int'(addr & 32'h0000_01FF);
        sz = 1; ld = 1'b0; sg = 1'b0; ok = 1'b1;
        case (op)
            6'b000000: begin sz = 4; ld = 1'b1; end
            6'b000001: begin sz = 1; ld = 1'b1; end
            6'b000010: begin sz = 2; ld = 1'b1; end
            6'b001001: begin sz = 1; ld = 1'b1; sg = 1'b1; end
            6'b001010: begin sz = 2; ld = 1'b1; sg = 1'b1; end
            6'b000100: sz = 4;
            6'b000101: sz = 1;
            6'b000110: sz = 2;
            default:   ok = 1'b0;
        endcase
        if (ok && (a % sz) != 0) ok = 1'b0;
        err = !ok;
        if (ok) begin
            if (ld) begin
                v = 0;
                for (int k = 0; k < sz; k++) v = v * 256 + longint'(mm[a + k]);
                if (sg && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
                m_dout = v[31:0];
            end else begin
                for (int k = 0; k < sz; k++) mm[a + k] = 8'(din >> (8 * (sz - 1 - k)));
            end
        end
    endtask

    // Driver: one full four-phase transaction with optional hold or early drop
    task automatic req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] din,
                       input int hold, input bit drop_mid);
        exp_t e;
        logic err;
        int   n;
        @(negedge clk);
        bus.RAM_enable = 1'b1;
        bus.RAM_OpCode = op;
        bus.Address    = addr;
        bus.DataIn     = din;
        model(op, addr, din, err);
        e.err  = err;
        e.dout = m_dout;
        e.cap  = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        bus.RAM_OpCode = 6'($urandom);
        bus.Address    = $urandom;
        bus.DataIn     = $urandom;
        if (drop_mid) bus.RAM_enable = 1'b0;
        n = 0;
        while (bus.MFC !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL mfc_timeout: got MFC=%b expected 1 within 20 cycles", bus.MFC);
            bus.RAM_enable = 1'b0;
            return;
        end
        if (!drop_mid) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("mfc_hold", 32'(bus.MFC), 32'd1);
            end
            bus.RAM_enable = 1'b0;
        end
        @(negedge clk);
        chk("mfc_clear", 32'(bus.MFC), 32'd0);
        chk("err_clear", 32'(bus.Error), 32'd0);
    endtask

    logic [5:0] ops [10];
    logic [5:0] rop;
    logic [31:0] raddr;

    initial begin
        ops = '{OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH, OP_ST, OP_STB, OP_STH, OP_LDD, OP_STD};
        rst            = 1'b1;
        bus.RAM_enable = 1'b0;
        bus.RAM_OpCode = 6'd0;
        bus.Address    = 32'd0;
        bus.DataIn     = 32'd0;
        m_dout         = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_mfc", 32'(bus.MFC), 32'd0);
        chk("reset_error", 32'(bus.Error), 32'd0);
        chk("reset_dataout", bus.DataOut, 32'h0000_0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_mfc", 32'(bus.MFC), 32'd0);
        end

        // Give every byte a known value
        for (int i = 0; i < DEPTH / 4; i++) req(OP_ST, 32'(i * 4), $urandom, 0, 1'b0);

        // Word round trip
        req(OP_ST, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
        req(OP_LD, 32'h10, 32'h0, 0, 1'b0);
        chk("ld_word", bus.DataOut, 32'hDEAD_BEEF);

        // Sub-word big-endian accesses
        req(OP_ST,   32'h20, 32'h80F1_7F02, 0, 1'b0);
        req(OP_LDUB, 32'h20, 32'h0, 0, 1'b0);
        chk("ldub", bus.DataOut, 32'h0000_0080);
        req(OP_LDSB, 32'h20, 32'h0, 0, 1'b0);
        chk("ldsb", bus.DataOut, 32'hFFFF_FF80);
        req(OP_LDUH, 32'h22, 32'h0, 0, 1'b0);
        chk("lduh", bus.DataOut, 32'h0000_7F02);
        req(OP_LDSH, 32'h20, 32'h0, 0, 1'b0);
        chk("ldsh", bus.DataOut, 32'hFFFF_80F1);
        req(OP_STB,  32'h23, 32'hAAAA_AA55, 0, 1'b0);
        req(OP_LD,   32'h20, 32'h0, 0, 1'b0);
        chk("stb_merge", bus.DataOut, 32'h80F1_7F55);

        // Error cases
        req(OP_LD,  32'h22, 32'h0, 0, 1'b0);
        chk("err_dout_kept", bus.DataOut, 32'h80F1_7F55);
        req(OP_STH, 32'h21, 32'h0000_BBBB, 0, 1'b0);
        req(OP_LD,  32'h20, 32'h0, 0, 1'b0);
        chk("sth_misaligned_nowrite", bus.DataOut, 32'h80F1_7F55);
        req(OP_LDD, 32'h20, 32'h0, 0, 1'b0);
        req(OP_STD, 32'h20, 32'h1111_1111, 0, 1'b0);

        // Handshake: long hold, then early drop during BUSY
        req(OP_LD, 32'h10, 32'h0, 5, 1'b0);
        req(OP_ST, 32'h30, 32'hCAFE_F00D, 0, 1'b1);
        req(OP_LD, 32'h30, 32'h0, 0, 1'b0);
        chk("drop_mid_committed", bus.DataOut, 32'hCAFE_F00D);

        // Upper address bits alias
        req(OP_LD, 32'hFFFF_FE10, 32'h0, 0, 1'b0);
        chk("alias_ld", bus.DataOut, 32'hDEAD_BEEF);

        // Reset in BUSY drops the store
        @(negedge clk);
        bus.RAM_enable = 1'b1;
        bus.RAM_OpCode = OP_ST;
        bus.Address    = 32'h40;
        bus.DataIn     = 32'h1234_5678;
        @(negedge clk);
        rst            = 1'b1;
        bus.RAM_enable = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        m_dout = 32'h0000_0000;
        chk("midreset_dataout", bus.DataOut, 32'h0000_0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midreset_no_mfc", 32'(bus.MFC), 32'd0);
        end
        req(OP_LD, 32'h40, 32'h0, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0) raddr[1:0] = 2'b00;
            req(rop, raddr, $urandom, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
